friscv_mc_sequencer: RTL and testbench

- Multicycle control sequencer for the next-generation FRiscV core.
- Replaces single-cycle fetch/execute with an FSM: FETCH, DECODE, EXEC, MEM, WB.
- Drives one unified instruction/data memory port through a req/ack handshake, so memory latency is variable.
- Holds PC, IR and result registers, and supplies register-file write enable and write data.
- The existing decoder, main controller, register file and ALU operate on its registered outputs.

---
 rtl/friscv_pkg.sv | 33 +++
 rtl/friscv_mc_sequencer_mem_timeout_cnt.sv | 27 ++
 rtl/friscv_mc_sequencer.sv | 174 +++++++++++++++++
 tb/tb_friscv_mc_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/friscv_pkg.sv
// Shared types and constants for the FRiscV multicycle sequencer.
package friscv_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        FAULT  = 3'd5
    } seq_state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam int PC_INCR = 4;

    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_OP, OP_OP_IMM, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal_op = 1'b1;
            default:                           is_legal_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/friscv_mc_sequencer_mem_timeout_cnt.sv
// Counts consecutive cycles a memory request has been pending without ack.
module mem_timeout_cnt #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic ack,
    output logic timeout_out
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (!req || ack)
            cnt <= '0;
        else if (cnt != CW'(MEM_TIMEOUT))
            cnt <= cnt + 1'b1;
    end

    // Fires in the last allowed wait cycle so an ack in that same cycle still wins.
    assign timeout_out = req && !ack && (cnt == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/friscv_mc_sequencer.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer over one req/ack memory port.
// Optional performance counters: define FRISCV_PERF_CNT_EN.
module friscv_mc_sequencer
    import friscv_pkg::*;
#(
    parameter int              ARCH_W      = 32,
    parameter logic [ARCH_W-1:0] RESET_PC  = '0,
    parameter int              MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req_out,
    output logic              mem_we_out,
    output logic [ARCH_W-1:0] mem_addr_out,
    output logic [ARCH_W-1:0] mem_wdata_out,
    input  logic [ARCH_W-1:0] mem_rdata_in,
    input  logic              mem_ack_in,
    input  logic [6:0]        op_code_in,
    input  logic [ARCH_W-1:0] imm_in,
    input  logic [ARCH_W-1:0] rs2_data_in,
    input  logic [ARCH_W-1:0] alu_result_in,
    input  logic              branch_taken_in,
    output logic [ARCH_W-1:0] instr_out,
    output logic [ARCH_W-1:0] pc_out,
    output logic              reg_write_out,
    output logic [ARCH_W-1:0] reg_write_data_out,
    output logic              fault_out,
    output logic [2:0]        state_out
`ifdef FRISCV_PERF_CNT_EN
    ,
    output logic [63:0]       cycle_cnt_out,
    output logic [63:0]       instret_cnt_out
`endif
);

    seq_state_t        state, state_d;
    logic [ARCH_W-1:0] pc, ir, alu_q, rs2_q, rdata_q;
    logic [ARCH_W-1:0] pc_plus4, pc_plus_imm, next_pc, wb_data;
    logic              pc_upd, ir_ld, ex_ld, rd_ld, misaligned, timeout;

    assign pc_plus4    = pc + ARCH_W'(PC_INCR);
    assign pc_plus_imm = pc + imm_in;

    always_comb begin
        next_pc = pc_plus4;
        case (op_code_in)
            OP_JAL:    next_pc = pc_plus_imm;
            OP_BRANCH: next_pc = branch_taken_in ? pc_plus_imm : pc_plus4;
            OP_JALR:   next_pc = {alu_q[ARCH_W-1:1], 1'b0};
            default:   next_pc = pc_plus4;
        endcase
    end

    assign misaligned = (next_pc[1:0] != 2'b00);

    always_comb begin
        wb_data = alu_q;
        case (op_code_in)
            OP_JAL, OP_JALR: wb_data = pc_plus4;
            OP_LUI:          wb_data = imm_in;
            OP_AUIPC:        wb_data = pc_plus_imm;
            OP_LOAD:         wb_data = rdata_q;
            default:         wb_data = alu_q;
        endcase
    end

    // Gating with rst_n drops an in-flight request the moment reset asserts.
    assign mem_req_out        = rst_n && (state == FETCH || state == MEM);
    assign mem_we_out         = mem_req_out && (state == MEM) && (op_code_in == OP_STORE);
    assign mem_addr_out       = !mem_req_out ? '0 : ((state == MEM) ? alu_q : pc);
    assign mem_wdata_out      = mem_we_out ? rs2_q : '0;
    assign reg_write_out      = rst_n && (state == WB) && !misaligned;
    assign reg_write_data_out = reg_write_out ? wb_data : '0;
    assign fault_out          = (state == FAULT);
    assign instr_out          = ir;
    assign pc_out             = pc;
    assign state_out          = state;

    mem_timeout_cnt #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tmo (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (mem_req_out),
        .ack         (mem_ack_in),
        .timeout_out (timeout)
    );

    always_comb begin
        state_d = state;
        pc_upd  = 1'b0;
        ir_ld   = 1'b0;
        ex_ld   = 1'b0;
        rd_ld   = 1'b0;
        case (state)
            FETCH: begin
                if (mem_ack_in) begin
                    ir_ld   = 1'b1;
                    state_d = DECODE;
                end else if (timeout) begin
                    state_d = FAULT;
                end
            end
            DECODE: state_d = is_legal_op(op_code_in) ? EXEC : FAULT;
            EXEC: begin
                ex_ld = 1'b1;
                if (op_code_in == OP_LOAD || op_code_in == OP_STORE)
                    state_d = MEM;
                else if (op_code_in == OP_BRANCH) begin
                    if (misaligned) state_d = FAULT;
                    else begin
                        pc_upd  = 1'b1;
                        state_d = FETCH;
                    end
                end else
                    state_d = WB;
            end
            MEM: begin
                if (mem_ack_in) begin
                    if (op_code_in == OP_LOAD) begin
                        rd_ld   = 1'b1;
                        state_d = WB;
                    end else if (misaligned) begin
                        state_d = FAULT;
                    end else begin
                        pc_upd  = 1'b1;
                        state_d = FETCH;
                    end
                end else if (timeout) begin
                    state_d = FAULT;
                end
            end
            WB: begin
                if (misaligned) state_d = FAULT;
                else begin
                    pc_upd  = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            alu_q   <= '0;
            rs2_q   <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_d;
            if (ir_ld) ir <= mem_rdata_in;
            if (ex_ld) begin
                alu_q <= alu_result_in;
                rs2_q <= rs2_data_in;
            end
            if (rd_ld)  rdata_q <= mem_rdata_in;
            if (pc_upd) pc      <= next_pc;
        end
    end

`ifdef FRISCV_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt_out   <= '0;
            instret_cnt_out <= '0;
        end else begin
            cycle_cnt_out <= cycle_cnt_out + 64'd1;
            if (pc_upd) instret_cnt_out <= instret_cnt_out + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_friscv_mc_sequencer.sv
// Directed bench for friscv_mc_sequencer with a per-cycle memory responder.
module tb_friscv_mc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req_out, mem_we_out, reg_write_out, fault_out;
    logic [31:0] mem_addr_out, mem_wdata_out, instr_out, pc_out, reg_write_data_out;
    logic [2:0]  state_out;
    logic [31:0] rdata = '0, imm = '0, rs2 = '0, alu = '0;
    logic        ack = 1'b0, taken = 1'b0;
    logic [6:0]  op_code_in;
`ifdef FRISCV_PERF_CNT_EN
    logic [63:0] cycle_cnt_out, instret_cnt_out;
`endif

    assign op_code_in = instr_out[6:0];

    always #5 clk = ~clk;

    friscv_mc_sequencer #(.ARCH_W(32), .RESET_PC(32'h100), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req_out(mem_req_out), .mem_we_out(mem_we_out),
        .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
        .mem_rdata_in(rdata), .mem_ack_in(ack),
        .op_code_in(op_code_in), .imm_in(imm), .rs2_data_in(rs2),
        .alu_result_in(alu), .branch_taken_in(taken),
        .instr_out(instr_out), .pc_out(pc_out),
        .reg_write_out(reg_write_out), .reg_write_data_out(reg_write_data_out),
        .fault_out(fault_out), .state_out(state_out)
`ifdef FRISCV_PERF_CNT_EN
        , .cycle_cnt_out(cycle_cnt_out), .instret_cnt_out(instret_cnt_out)
`endif
    );

    localparam logic [31:0] I_ADDI  = 32'h0050_0093;
    localparam logic [31:0] I_LOAD  = 32'h0000_2083;
    localparam logic [31:0] I_STORE = 32'h0010_2223;
    localparam logic [31:0] I_BR    = 32'h0000_0063;
    localparam logic [31:0] I_JAL   = 32'h0000_006F;
    localparam logic [31:0] I_JALR  = 32'h0000_0067;
    localparam logic [31:0] I_LUI   = 32'h0000_0037;
    localparam logic [31:0] I_AUIPC = 32'h0000_0017;
    localparam logic [31:0] I_ILL   = 32'h0000_007F;

    int checks = 0, failures = 0;
    int fetch_wait = 0, mem_wait = 0, wcnt = 0;
    logic [31:0] ir_val = '0, ld_val = '0;

    int          r_lat, r_nwr, r_nwe, r_nreq;
    logic [31:0] r_wd, r_waddr, r_wdat, r_maddr, r_faddr;
    logic        r_stable;

    // Runs one instruction from its first FETCH cycle, acting as memory and recording activity.
    task automatic run_instr(input int max);
        logic        left, pend;
        logic [31:0] paddr;
        r_lat = 0; r_nwr = 0; r_nwe = 0; r_nreq = 0; r_stable = 1'b1;
        r_wd = '0; r_waddr = '0; r_wdat = '0; r_maddr = '0;
        left = 1'b0; pend = 1'b0; paddr = '0;
        r_faddr = mem_addr_out;
        forever begin
            if (reg_write_out) begin r_nwr++; r_wd = reg_write_data_out; end
            if (mem_we_out) begin r_nwe++; r_waddr = mem_addr_out; r_wdat = mem_wdata_out; end
            if (mem_req_out) begin
                r_nreq++;
                if (state_out == 3'd3) r_maddr = mem_addr_out;
                if (pend && mem_addr_out != paddr) r_stable = 1'b0;
                if (wcnt >= ((state_out == 3'd3) ? mem_wait : fetch_wait)) begin
                    ack = 1'b1; rdata = (state_out == 3'd3) ? ld_val : ir_val; wcnt = 0;
                end else begin
                    ack = 1'b0; rdata = '0; wcnt++;
                end
            end else begin
                ack = 1'b0; wcnt = 0;
            end
            pend = mem_req_out && !ack;
            paddr = mem_addr_out;
            r_lat++;
            @(negedge clk);
            if (state_out != 3'd0) left = 1'b1;
            if ((left && state_out == 3'd0) || state_out == 3'd5 || r_lat >= max) break;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; ack = 1'b0; wcnt = 0; fetch_wait = 0; mem_wait = 0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (state_out !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state_out); end
        checks++; if (pc_out !== 32'h100) begin failures++; $display("FAIL rst_pc got=%h exp=00000100", pc_out); end
        checks++; if ({mem_req_out, mem_we_out, reg_write_out, fault_out} !== 4'b0) begin
            failures++; $display("FAIL rst_ctrl got=%b exp=0000", {mem_req_out, mem_we_out, reg_write_out, fault_out}); end
        checks++; if ({instr_out, mem_addr_out, reg_write_data_out} !== 96'b0) begin
            failures++; $display("FAIL rst_data got=%h exp=0", {instr_out, mem_addr_out, reg_write_data_out}); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({mem_req_out, mem_we_out} !== 2'b10) begin failures++; $display("FAIL rel_req got=%b exp=10", {mem_req_out, mem_we_out}); end
        checks++; if (mem_addr_out !== 32'h100) begin failures++; $display("FAIL rel_addr got=%h exp=00000100", mem_addr_out); end
    endtask

    task automatic test_addi();
        ir_val = I_ADDI; alu = 32'd5;
        run_instr(200);
        checks++; if (r_faddr !== 32'h100) begin failures++; $display("FAIL addi_faddr got=%h exp=00000100", r_faddr); end
        checks++; if (r_lat !== 4) begin failures++; $display("FAIL addi_lat got=%0d exp=4", r_lat); end
        checks++; if (r_nwr !== 1 || r_wd !== 32'd5) begin failures++; $display("FAIL addi_wr got=%0d/%h exp=1/00000005", r_nwr, r_wd); end
        checks++; if (mem_addr_out !== 32'h104 || !mem_req_out) begin failures++; $display("FAIL addi_next got=%h exp=00000104", mem_addr_out); end
    endtask

    task automatic test_load();
        ir_val = I_LOAD; alu = 32'h200; ld_val = 32'hDEAD_BEEF; mem_wait = 3;
        run_instr(200);
        mem_wait = 0;
        checks++; if (r_lat !== 8) begin failures++; $display("FAIL load_lat got=%0d exp=8", r_lat); end
        checks++; if (r_maddr !== 32'h200 || !r_stable) begin failures++; $display("FAIL load_addr got=%h stable=%b exp=00000200/1", r_maddr, r_stable); end
        checks++; if (r_nwr !== 1 || r_wd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_wr got=%0d/%h exp=1/deadbeef", r_nwr, r_wd); end
        checks++; if (r_nwe !== 0 || pc_out !== 32'h108) begin failures++; $display("FAIL load_pc got=we%0d/%h exp=we0/00000108", r_nwe, pc_out); end
    endtask

    task automatic test_store();
        ir_val = I_STORE; alu = 32'h204; rs2 = 32'h1234;
        run_instr(200);
        checks++; if (r_nwe !== 1 || r_waddr !== 32'h204 || r_wdat !== 32'h1234) begin
            failures++; $display("FAIL store_we got=%0d/%h/%h exp=1/00000204/00001234", r_nwe, r_waddr, r_wdat); end
        checks++; if (r_nwr !== 0) begin failures++; $display("FAIL store_nowr got=%0d exp=0", r_nwr); end
        checks++; if (r_lat !== 4 || pc_out !== 32'h10C) begin failures++; $display("FAIL store_pc got=%0d/%h exp=4/0000010c", r_lat, pc_out); end
    endtask

    task automatic test_branch();
        ir_val = I_ADDI; alu = 32'd5;
        run_instr(200);
        ir_val = I_BR; imm = 32'hFFFF_FFF0; taken = 1'b1;
        run_instr(200);
        checks++; if (r_lat !== 3 || r_nwr !== 0) begin failures++; $display("FAIL br_taken_lat got=%0d/%0d exp=3/0", r_lat, r_nwr); end
        checks++; if (pc_out !== 32'h100) begin failures++; $display("FAIL br_taken_pc got=%h exp=00000100", pc_out); end
        ir_val = I_ADDI; taken = 1'b0;
        for (int i = 0; i < 4; i++) run_instr(200);
        checks++; if (pc_out !== 32'h110) begin failures++; $display("FAIL br_setup_pc got=%h exp=00000110", pc_out); end
        ir_val = I_BR;
        run_instr(200);
        checks++; if (r_lat !== 3 || pc_out !== 32'h114) begin failures++; $display("FAIL br_nt got=%0d/%h exp=3/00000114", r_lat, pc_out); end
    endtask

    task automatic test_jumps();
        ir_val = I_JAL; imm = 32'h20;
        run_instr(200);
        checks++; if (r_lat !== 4 || r_wd !== 32'h118 || pc_out !== 32'h134) begin
            failures++; $display("FAIL jal got=%0d/%h/%h exp=4/00000118/00000134", r_lat, r_wd, pc_out); end
        ir_val = I_AUIPC; imm = 32'h1000;
        run_instr(200);
        checks++; if (r_wd !== 32'h1134 || pc_out !== 32'h138) begin failures++; $display("FAIL auipc got=%h/%h exp=00001134/00000138", r_wd, pc_out); end
        ir_val = I_LUI; imm = 32'hABCD_E000;
        run_instr(200);
        checks++; if (r_wd !== 32'hABCD_E000 || pc_out !== 32'h13C) begin failures++; $display("FAIL lui got=%h/%h exp=abcde000/0000013c", r_wd, pc_out); end
        ir_val = I_JALR; alu = 32'h301;
        run_instr(200);
        checks++; if (r_nwr !== 1 || r_wd !== 32'h140 || pc_out !== 32'h300) begin
            failures++; $display("FAIL jalr got=%0d/%h/%h exp=1/00000140/00000300", r_nwr, r_wd, pc_out); end
    endtask

    task automatic test_illegal();
        ir_val = I_ILL;
        run_instr(200);
        checks++; if (r_lat !== 2 || fault_out !== 1'b1 || state_out !== 3'd5) begin
            failures++; $display("FAIL illegal got=%0d/%b/%0d exp=2/1/5", r_lat, fault_out, state_out); end
        checks++; if (pc_out !== 32'h300) begin failures++; $display("FAIL illegal_pc got=%h exp=00000300", pc_out); end
    endtask

    task automatic test_jalr_fault();
        int nreq;
        do_reset();
        ir_val = I_JALR; alu = 32'h203;
        run_instr(200);
        checks++; if (fault_out !== 1'b1 || r_nwr !== 0 || r_lat !== 4) begin
            failures++; $display("FAIL jalr_mis got=%b/%0d/%0d exp=1/0/4", fault_out, r_nwr, r_lat); end
        ack = 1'b1; nreq = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_req_out || reg_write_out) nreq++;
        end
        ack = 1'b0;
        checks++; if (nreq !== 0 || fault_out !== 1'b1 || pc_out !== 32'h100) begin
            failures++; $display("FAIL fault_hold got=%0d/%b/%h exp=0/1/00000100", nreq, fault_out, pc_out); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ir_val = I_STORE; alu = 32'h204; rs2 = 32'h55; mem_wait = 100;
        run_instr(5);
        checks++; if (state_out !== 3'd3 || mem_req_out !== 1'b1) begin
            failures++; $display("FAIL mid_setup got=%0d/%b exp=3/1", state_out, mem_req_out); end
        rst_n = 1'b0; ack = 1'b0;
        #1;
        checks++; if ({mem_req_out, mem_we_out, reg_write_out} !== 3'b000) begin
            failures++; $display("FAIL mid_drop got=%b exp=000", {mem_req_out, mem_we_out, reg_write_out}); end
        @(negedge clk);
        checks++; if (state_out !== 3'd0 || pc_out !== 32'h100) begin
            failures++; $display("FAIL mid_rst got=%0d/%h exp=0/00000100", state_out, pc_out); end
    endtask

    task automatic test_timeout();
        do_reset();
        ir_val = I_ADDI; alu = 32'd5; fetch_wait = 1000;
        run_instr(100);
        checks++; if (r_nreq !== 16 || fault_out !== 1'b1 || mem_req_out !== 1'b0) begin
            failures++; $display("FAIL tmo got=%0d/%b/%b exp=16/1/0", r_nreq, fault_out, mem_req_out); end
`ifdef FRISCV_PERF_CNT_EN
        checks++; if (instret_cnt_out !== 64'd0) begin failures++; $display("FAIL tmo_instret got=%0d exp=0", instret_cnt_out); end
`endif
        do_reset();
        fetch_wait = 15;
        run_instr(100);
        checks++; if (fault_out !== 1'b0 || r_lat !== 19 || r_nwr !== 1) begin
            failures++; $display("FAIL tmo_ack got=%b/%0d/%0d exp=0/19/1", fault_out, r_lat, r_nwr); end
        checks++; if (pc_out !== 32'h104) begin failures++; $display("FAIL tmo_ack_pc got=%h exp=00000104", pc_out); end
`ifdef FRISCV_PERF_CNT_EN
        checks++; if (instret_cnt_out !== 64'd1 || cycle_cnt_out !== 64'd19) begin
            failures++; $display("FAIL perf got=%0d/%0d exp=1/19", instret_cnt_out, cycle_cnt_out); end
`endif
        fetch_wait = 0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load();
        test_store();
        test_branch();
        test_jumps();
        test_illegal();
        test_jalr_fault();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
